// File: rtl/nn_pixel_streamer.sv
// Frame source for the image pipeline: a host loads one IMG_W x IMG_H frame, then
// start replays it in raster order with coordinates, frame/line markers and optional gaps.
module nn_pixel_streamer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 9,
  parameter int GAP   = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [$clog2(IMG_W*IMG_H)-1:0]  wr_addr,
  input  logic signed [PIX_W-1:0]         wr_data,
  input  logic                            start,
  input  logic                            pause,
  output logic                            out_valid,
  output logic signed [PIX_W-1:0]         out_pixel,
  output logic [$clog2(IMG_W)-1:0]        out_x,
  output logic [$clog2(IMG_H)-1:0]        out_y,
  output logic                            sof,
  output logic                            eol,
  output logic                            eof,
  output logic                            busy,
  output logic                            done,
  output logic                            wr_err
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        addr;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [3:0]           gap_cnt;
  logic                 issue, x_end, last, in_range, streaming;
  logic signed [PIX_W-1:0] mem [N];

  assign streaming = (state == S_STREAM) || (state == S_GAP);
  // Zero-extend so the range check stays meaningful when N is a power of two.
  assign in_range  = {1'b0, wr_addr} < (AW+1)'(N);
  assign x_end     = (x == XW'(IMG_W-1));
  assign last      = x_end && (y == YW'(IMG_H-1));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if (!pause) begin
        issue = 1'b1;
        if (last)         state_nxt = S_DONE;
        else if (GAP > 0) state_nxt = S_GAP;
      end
      S_GAP:    if (gap_cnt <= 4'd1) state_nxt = S_STREAM;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Buffer survives reset; writes are locked out while a frame is in flight.
  always_ff @(posedge clk)
    if (wr_en && in_range && !streaming) mem[wr_addr] <= wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      x         <= '0;
      y         <= '0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_x     <= '0;
      out_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= issue;
      sof       <= issue && (addr == '0);
      eol       <= issue && x_end;
      eof       <= issue && last;
      done      <= (state == S_DONE);
      wr_err    <= wr_en && in_range && streaming;
      if (state == S_IDLE && start) begin
        busy <= 1'b1;
        addr <= '0;
        x    <= '0;
        y    <= '0;
      end
      if (state == S_DONE) busy <= 1'b0;
      if (state == S_GAP)  gap_cnt <= gap_cnt - 4'd1;
      if (issue) begin
        out_pixel <= mem[addr];
        out_x     <= x;
        out_y     <= y;
        addr      <= addr + 1'b1;
        gap_cnt   <= 4'(GAP);
        if (x_end) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_nn_pixel_streamer.sv
// Scoreboard bench for nn_pixel_streamer: a GAP=0 instance for timing/pause/reset/write-lock
// scenarios and a GAP=2 instance for issue spacing; both share the write port.
module tb_nn_pixel_streamer;
  localparam int W = 8, H = 8, PW = 9, N = W*H;

  typedef struct {
    logic signed [PW-1:0] pix;
    logic [2:0] x, y;
    logic sof, eol, eof;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, start0 = 1'b0, start2 = 1'b0, pause = 1'b0;
  logic [5:0] wr_addr = '0;
  logic signed [PW-1:0] wr_data = '0;

  logic out_valid0, sof0, eol0, eof0, busy0, done0, wr_err0;
  logic signed [PW-1:0] out_pixel0;
  logic [2:0] out_x0, out_y0;
  logic out_valid2, sof2, eol2, eof2, busy2, done2, wr_err2;
  logic signed [PW-1:0] out_pixel2;
  logic [2:0] out_x2, out_y2;

  nn_pixel_streamer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start0), .pause(pause), .out_valid(out_valid0), .out_pixel(out_pixel0),
    .out_x(out_x0), .out_y(out_y0), .sof(sof0), .eol(eol0), .eof(eof0),
    .busy(busy0), .done(done0), .wr_err(wr_err0));

  nn_pixel_streamer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start2), .pause(1'b0), .out_valid(out_valid2), .out_pixel(out_pixel2),
    .out_x(out_x2), .out_y(out_y2), .sof(sof2), .eol(eol2), .eof(eof2),
    .busy(busy2), .done(done2), .wr_err(wr_err2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic signed [PW-1:0] model [N];
  exp_t sbq [$];
  int first_vld, last_vld, nvld, done_cyc, done_cnt = 0, err_cnt = 0, k_cyc;
  int first2, last2, n2, done2_cyc;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // dut0 monitor: scoreboard pop plus marker/done bookkeeping
  always @(negedge clk) if (rst_n) begin
    if (out_valid0) begin
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      nvld++;
      if (sbq.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pix", out_pixel0, e.pix);
        chk("x", out_x0, e.x);
        chk("y", out_y0, e.y);
        chk("sof", sof0, e.sof);
        chk("eol", eol0, e.eol);
        chk("eof", eof0, e.eof);
      end
    end else begin
      chk("mk_off", {sof0, eol0, eof0}, 0);
    end
    if (done0) begin
      done_cyc = cyc;
      done_cnt++;
      chk("busy_at_done", busy0, 0);
    end
    if (wr_err0) err_cnt++;
  end

  // dut2 monitor: spacing and value against the model
  always @(negedge clk) if (rst_n) begin
    if (out_valid2) begin
      if (n2 > 0) chk("gap_space", cyc - last2, 3);
      else first2 = cyc;
      if (n2 < N) chk("gap_pix", out_pixel2, model[n2]);
      else chk("gap_extra", n2, N - 1);
      last2 = cyc;
      n2++;
    end
    if (done2) done2_cyc = cyc;
  end

  task automatic wr(input int a, input logic signed [PW-1:0] d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.pix = model[i]; e.x = 3'(i % W); e.y = 3'(i / W);
      e.sof = (i == 0); e.eol = (i % W == W - 1); e.eof = (i == N - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic start_frame(input bit sel2);
    if (sel2) begin
      first2 = -1; n2 = 0; done2_cyc = -1; start2 = 1'b1;
    end else begin
      push_frame();
      first_vld = -1; nvld = 0; done_cyc = -1; start0 = 1'b1;
    end
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    k_cyc = cyc;
    if (!sel2) chk("busy_on", busy0, 1);
  endtask

  task automatic wait_done(input bit sel2, input int budget);
    int n = 0;
    while ((sel2 ? done2_cyc : done_cyc) < 0 && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    if ((sel2 ? done2_cyc : done_cyc) < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_nvld(input int target, input int budget);
    int n = 0;
    while (nvld < target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    if (nvld < target) chk("nvld_timeout", nvld, target);
  endtask

  initial begin
    first_vld = -1; nvld = 0; done_cyc = -1; n2 = 0; first2 = -1; done2_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid0, 0);
    chk("rst_pixel", out_pixel0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_xy", {out_x0, out_y0}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load i-32 and stream with GAP=0
    for (int i = 0; i < N; i++) begin
      model[i] = PW'(i - 32);
      wr(i, model[i]);
    end
    start_frame(0);
    wait_done(0, 200);
    chk("first_lat", first_vld - k_cyc, 1);
    chk("span", last_vld - first_vld, N - 1);
    chk("nvld", nvld, N);
    chk("done_lat", done_cyc - last_vld, 1);
    chk("done_edge", done_cyc - k_cyc, N + 1);
    chk("sb_left", sbq.size(), 0);

    // Pause for 5 cycles after pixel 20
    repeat (2) @(posedge clk); #1;
    start_frame(0);
    wait_nvld(21, 100);
    pause = 1'b1;
    repeat (5) @(posedge clk);
    #1; pause = 1'b0;
    wait_done(0, 200);
    chk("pause_span", last_vld - first_vld, N - 1 + 5);
    chk("pause_nvld", nvld, N);
    chk("pause_sb_left", sbq.size(), 0);

    // GAP=2 instance spacing
    repeat (2) @(posedge clk); #1;
    start_frame(1);
    wait_done(1, 400);
    chk("gap_n", n2, N);
    chk("gap_span", last2 - first2, 3 * (N - 1));
    chk("gap_first", first2 - k_cyc, 1);

    // Start and a write to addr 5 while streaming
    repeat (2) @(posedge clk); #1;
    start_frame(0);
    repeat (10) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 9'sd100; start0 = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; start0 = 1'b0;
    chk("wr_err_pulse", wr_err0, 1);
    @(posedge clk); #1;
    chk("wr_err_once", wr_err0, 0);
    wait_done(0, 200);
    repeat (5) @(posedge clk); #1;
    chk("restart_ignored_busy", busy0, 0);
    chk("restart_ignored_n", nvld, N);
    chk("wr_err_cnt", err_cnt, 1);
    start_frame(0);
    wait_done(0, 200);
    chk("rerun_sb_left", sbq.size(), 0);

    // Reset at pixel 30
    repeat (2) @(posedge clk); #1;
    start_frame(0);
    wait_nvld(31, 100);
    begin
      int dc;
      dc = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid0, 0);
      chk("midrst_busy", busy0, 0);
      chk("midrst_pixel", out_pixel0, 0);
      sbq.delete();
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("midrst_no_done", done_cnt, dc);
      chk("midrst_idle", busy0, 0);
    end
    start_frame(0);
    wait_done(0, 200);
    chk("replay_nvld", nvld, N);
    chk("replay_sb_left", sbq.size(), 0);

    // Write and start on the same edge
    repeat (2) @(posedge clk); #1;
    model[0] = -9'sd256;
    push_frame();
    first_vld = -1; nvld = 0; done_cyc = -1;
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = -9'sd256; start0 = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; start0 = 1'b0;
    wait_done(0, 200);
    chk("wrstart_nvld", nvld, N);
    chk("wrstart_sb_left", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nn_pixel_streamer.md
Name: nn_pixel_streamer

Overview:
Frame source that drives the pixel-stream input of the image pipeline: in_valid and a signed 9-bit pixel, in raster order. A host loads one IMG_W x IMG_H frame into an internal buffer through a write port, then pulses start. The block replays the frame one pixel per issue slot, with optional inter-pixel gaps and a pause input. It also emits raster coordinates and frame/line markers for scoreboarding against the pipeline's out_x/out_y.

Parameters:
IMG_W, 8, frame width in pixels (>=3)
IMG_H, 8, frame height in pixels (>=3)
PIX_W, 9, pixel width, signed
GAP, 0, idle cycles inserted after every issued pixel (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  frame-buffer write strobe
wr_addr  in  $clog2(IMG_W*IMG_H)  raster address, y*IMG_W+x
wr_data  in  PIX_W  signed pixel to store
start  in  1  begin streaming the frame (level sampled, acted on in IDLE only)
pause  in  1  hold issue while high
out_valid  out  1  pixel valid; connects to the pipeline's in_valid
out_pixel  out  PIX_W  signed pixel; connects to in_pixel
out_x  out  $clog2(IMG_W)  column of out_pixel
out_y  out  $clog2(IMG_H)  row of out_pixel
sof  out  1  high with pixel (0,0)
eol  out  1  high with the last pixel of each row
eof  out  1  high with the last pixel of the frame
busy  out  1  high from the start-accept edge until the frame is finished
done  out  1  one-cycle pulse after the last pixel
wr_err  out  1  one-cycle pulse when a write arrives while busy

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous assert, synchronous deassert at the boundary.
- Reset values: all outputs 0; state IDLE; address and gap counters 0.
- Reset does not clear the frame buffer. A reset mid-frame returns to IDLE immediately, with out_valid=0, and produces no done pulse.
- Writes:
  - In IDLE/DONE, wr_en writes mem[wr_addr] at the edge.
  - In STREAM/GAP, wr_en is ignored and wr_err pulses high for one cycle after that edge.
  - wr_addr >= IMG_W*IMG_H is ignored and sets no flag.
- FSM states: IDLE, STREAM, GAP, DONE.
  - IDLE: start=1 at edge k -> STREAM; busy=1 from edge k; address=0.
  - STREAM, pause=0 at an edge: register out_valid=1, out_pixel=mem[addr], out_x, out_y, sof/eol/eof, then advance addr.
    - If this was the last pixel -> DONE.
    - Else if GAP>0 -> GAP, with gap count=GAP.
    - Else stay in STREAM.
  - STREAM, pause=1 at an edge: out_valid=0 and no advance. Pause is re-evaluated every edge.
  - GAP: out_valid=0; decrement count each edge and return to STREAM when it reaches 1. pause does not stall the gap count.
  - DONE: one cycle; done=1, busy=0, out_valid=0; next state IDLE.
- Latency with GAP=0 and no pause:
  - Pixel 0 is valid in the cycle after edge k+1.
  - Pixel n is issued at edge k+1+n.
  - done and busy-low are at edge k+1+IMG_W*IMG_H.
- Spacing with GAP=g: consecutive pixels are g+1 cycles apart.
- Coordinates: x wraps to 0 after IMG_W-1 and y then increments; y does not wrap within a frame.
- Markers:
  - sof, eol and eof are valid only while out_valid=1, otherwise 0.
  - eol and eof coincide on the last pixel.
- start handling: start while busy is ignored. Holding start high in IDLE after DONE launches a new frame; back-to-back frames have exactly one DONE cycle between them.
- Write and start at the same edge in IDLE: the write commits first, so the frame streams the new value.
- out_pixel: passed through unmodified (signed, PIX_W bits); holds its last value when out_valid=0.

Test Plan:
- Load mem[i]=i-32 (signed), GAP=0, pulse start -> 64 consecutive valid cycles with pixel i-32.
  - x/y follow raster order.
  - sof on (0,0); eol on x=7; eof on (7,7).
  - done exactly one cycle after the last pixel; busy low at the same edge.
- Same frame, pause high for 5 cycles after pixel 20 -> 5 cycles with out_valid=0, then pixel 21 resumes; no pixel is lost or duplicated.
- GAP=2 -> valid pulses 3 cycles apart; total frame span 1+3*63 cycles from the first valid.
- Start pulsed during streaming, plus wr_en at addr 5 during streaming -> start ignored; wr_err pulses once; a rerun shows mem[5] unchanged.
- rst_n low at pixel 30 -> outputs 0 immediately, no done; after release, a new start replays from pixel 0 with the buffer contents intact.
- wr_en to addr 0 with value -256 in the same cycle as start in IDLE -> first streamed pixel is -256.
